// File: rtl/instr_encoder_if.sv
// Request/result bundle for the MIPS instruction encoder.
//   Request : in_valid/in_ready handshake with kind, opcode, funct, rs, rt, rd, shamt, imm, target.
//   Result  : out_valid/out_ready handshake with instr and out_class, plus err pulse and
//             err_opcode (opcode of the most recently rejected request).
// master drives requests and consumes results; slave is the encoder.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  kind;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [31:0] imm;
   logic [25:0] target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [1:0]  out_class;
   logic        err;
   logic [5:0]  err_opcode;

   modport master (
      output in_valid, kind, opcode, funct, rs, rt, rd, shamt, imm, target, out_ready,
      input  in_ready, out_valid, instr, out_class, err, err_opcode
   );

   modport slave (
      input  in_valid, kind, opcode, funct, rs, rt, rd, shamt, imm, target, out_ready,
      output in_ready, out_valid, instr, out_class, err, err_opcode
   );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder with pseudo-instruction expansion.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : instr_encoder_if.slave (request in, encoded word out, error report)
// Each accepted request produces one 32-bit word (R/I/J format), two words for LI with a
// nonzero upper half (lui then ori), or none with an err pulse for an illegal opcode/kind.
// The output is a single registered entry; a drain and a new accept may happen together.
module instr_encoder (
   input logic            clock,
   input logic            reset,
   instr_encoder_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StEmit, StEmitHi} state_e;

   localparam logic [2:0] KindR    = 3'd0;
   localparam logic [2:0] KindI    = 3'd1;
   localparam logic [2:0] KindJ    = 3'd2;
   localparam logic [2:0] KindLi   = 3'd3;
   localparam logic [2:0] KindMove = 3'd4;
   localparam logic [2:0] KindB    = 3'd5;
   localparam logic [2:0] KindBnez = 3'd6;

   localparam logic [5:0] OpSpecial = 6'b000000;
   localparam logic [5:0] OpRegimm  = 6'b000001;
   localparam logic [5:0] OpJ       = 6'b000010;
   localparam logic [5:0] OpJal     = 6'b000011;
   localparam logic [5:0] OpBeq     = 6'b000100;
   localparam logic [5:0] OpBne     = 6'b000101;
   localparam logic [5:0] OpBlez    = 6'b000110;
   localparam logic [5:0] OpBgtz    = 6'b000111;
   localparam logic [5:0] OpAddiu   = 6'b001001;
   localparam logic [5:0] OpSlti    = 6'b001010;
   localparam logic [5:0] OpSltiu   = 6'b001011;
   localparam logic [5:0] OpOri     = 6'b001101;
   localparam logic [5:0] OpLui     = 6'b001111;
   localparam logic [5:0] OpLb      = 6'b100000;
   localparam logic [5:0] OpLw      = 6'b100011;
   localparam logic [5:0] OpSb      = 6'b101000;
   localparam logic [5:0] OpSw      = 6'b101011;
   localparam logic [5:0] FnAddu    = 6'b100001;

   localparam logic [1:0] ClsR = 2'd1;
   localparam logic [1:0] ClsI = 2'd2;
   localparam logic [1:0] ClsJ = 2'd3;

   state_e      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [1:0]  class_q, class_d;
   logic        err_q, err_d;
   logic [5:0]  err_op_q, err_op_d;
   // Held for the second LI word so the request bus is free after acceptance.
   logic [4:0]  li_rt_q, li_rt_d;
   logic [15:0] li_lo_q, li_lo_d;

   logic        dec_ok, dec_two;
   logic [31:0] dec_instr;
   logic [1:0]  dec_class;
   logic        in_ready, accept;

   // Decode the presented request into its first word.
   always_comb begin
      dec_ok    = 1'b1;
      dec_two   = 1'b0;
      dec_instr = '0;
      dec_class = 2'd0;
      case (bus.kind)
         KindR: begin
            dec_ok    = (bus.opcode == OpSpecial);
            dec_instr = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
            dec_class = ClsR;
         end
         KindI: begin
            case (bus.opcode)
               OpAddiu, OpLui, OpLw, OpLb, OpSw, OpSb, OpRegimm, OpBne, OpBeq, OpBgtz,
               OpBlez, OpOri, OpSlti, OpSltiu: dec_ok = 1'b1;
               default:                        dec_ok = 1'b0;
            endcase
            dec_instr = {bus.opcode, bus.rs, bus.rt, bus.imm[15:0]};
            dec_class = ClsI;
         end
         KindJ: begin
            dec_ok    = (bus.opcode == OpJ) || (bus.opcode == OpJal);
            dec_instr = {bus.opcode, bus.target};
            dec_class = ClsJ;
         end
         KindLi: begin
            // A zero upper half collapses to a single ori from $zero.
            if (bus.imm[31:16] == 16'h0000) begin
               dec_instr = {OpOri, 5'd0, bus.rt, bus.imm[15:0]};
            end else begin
               dec_two   = 1'b1;
               dec_instr = {OpLui, 5'd0, bus.rt, bus.imm[31:16]};
            end
            dec_class = ClsI;
         end
         KindMove: begin
            dec_instr = {OpSpecial, 5'd0, bus.rt, bus.rd, 5'd0, FnAddu};
            dec_class = ClsR;
         end
         KindB: begin
            dec_instr = {OpBeq, 5'd0, 5'd0, bus.imm[15:0]};
            dec_class = ClsI;
         end
         KindBnez: begin
            dec_instr = {OpBne, 5'd0, bus.rt, bus.imm[15:0]};
            dec_class = ClsI;
         end
         default: dec_ok = 1'b0;
      endcase
   end

   assign in_ready = (state_q == StIdle) || ((state_q == StEmit) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      class_d  = class_q;
      err_d    = 1'b0;
      err_op_d = err_op_q;
      li_rt_d  = li_rt_q;
      li_lo_d  = li_lo_q;
      unique case (state_q)
         StIdle, StEmit: begin
            if ((state_q == StEmit) && bus.out_ready) begin
               state_d = StIdle;
            end
            if (accept) begin
               if (!dec_ok) begin
                  // Rejected: consumed like a drain, leaves no word behind.
                  err_d    = 1'b1;
                  err_op_d = bus.opcode;
               end else begin
                  instr_d = dec_instr;
                  class_d = dec_class;
                  state_d = dec_two ? StEmitHi : StEmit;
                  if (dec_two) begin
                     li_rt_d = bus.rt;
                     li_lo_d = bus.imm[15:0];
                  end
               end
            end
         end
         StEmitHi: begin
            if (bus.out_ready) begin
               instr_d = {OpOri, li_rt_q, li_rt_q, li_lo_q};
               class_d = ClsI;
               state_d = StEmit;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         instr_q  <= '0;
         class_q  <= '0;
         err_q    <= 1'b0;
         err_op_q <= '0;
         li_rt_q  <= '0;
         li_lo_q  <= '0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         class_q  <= class_d;
         err_q    <= err_d;
         err_op_q <= err_op_d;
         li_rt_q  <= li_rt_d;
         li_lo_q  <= li_lo_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = (state_q != StIdle);
   assign bus.instr      = instr_q;
   assign bus.out_class  = class_q;
   assign bus.err        = err_q;
   assign bus.err_opcode = err_op_q;

endmodule
